feature_conv11_reader: RTL and testbench

Burst read controller downstream of the 1x1-conv feature FIFO (64-bit write, 256-bit read). It programs the FIFO's M_count threshold to one row of words and waits for M_Ready. It then drains exactly one row into a 2-entry output skid buffer with a valid/ready handshake toward the 1x1 PE array. After the last row of a layer it pulses Next_Reg to flush the FIFO and signals Done.

---
 rtl/feature_conv11_reader.sv | 176 +++++++++++++++++
 tb/tb_feature_conv11_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_conv11_reader.sv
// Burst reader between the 1x1-conv feature FIFO and the 1x1 PE array.
// Drains one row per M_Ready into a 2-entry skid buffer; flushes FIFO at layer end.
module feature_conv11_reader #(
  parameter int WIDTH     = 256,
  parameter int ADDR_BITS = 10,
  parameter int ROW_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [ADDR_BITS:0]   Row_Words,
  input  logic [ROW_BITS-1:0]  Row_Num,
  input  logic                 M_Ready,
  output logic [ADDR_BITS:0]   M_count,
  output logic                 rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 Next_Reg,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 Done,
  output logic                 Busy
);

  typedef enum logic [2:0] {
    IDLE, GAP, WAIT, READ, DRAIN, FLUSH
  } state_t;

  localparam logic [ADDR_BITS:0]  W_ONE = 1;
  localparam logic [ROW_BITS-1:0] R_ONE = 1;

  state_t               state;
  logic [ADDR_BITS:0]   rw_q;
  logic [ADDR_BITS:0]   issued;
  logic [ROW_BITS-1:0]  rn_q;
  logic [ROW_BITS-1:0]  row_cnt;
  logic [1:0]           gap_cnt;

  logic                 inflight;
  logic                 inflight_last;
  logic [WIDTH-1:0]     buf_data [2];
  logic                 buf_last [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;

  logic                 pop;
  logic [1:0]           occ_eff;
  logic [2:0]           credit;
  logic                 last_word;

  assign dout_valid = (count != 2'd0);
  assign dout       = buf_data[rd_ptr];
  assign dout_last  = dout_valid & buf_last[rd_ptr];
  assign pop        = dout_valid & dout_ready;

  // A word popped this cycle frees its slot for a read issued this cycle.
  assign occ_eff    = count - {1'b0, pop};
  assign credit     = {1'b0, occ_eff} + {2'b00, inflight};
  assign last_word  = (issued == rw_q - W_ONE);
  assign rd_en      = (state == READ) &&
                      (issued < rw_q) &&
                      (credit < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en & last_word;
      if (inflight) begin
        buf_data[wr_ptr] <= fifo_dout;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rw_q     <= '0;
      rn_q     <= '0;
      M_count  <= '0;
      issued   <= '0;
      row_cnt  <= '0;
      gap_cnt  <= '0;
      Next_Reg <= 1'b0;
      Done     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Next_Reg <= 1'b0;
      Done     <= 1'b0;
      if (rd_en) begin
        issued <= issued + W_ONE;
      end
      unique case (state)
        IDLE: begin
          if (Start) begin
            rw_q    <= Row_Words;
            rn_q    <= Row_Num;
            M_count <= Row_Words;
            issued  <= '0;
            row_cnt <= '0;
            gap_cnt <= '0;
            Busy    <= 1'b1;
            if (Row_Words == '0 || Row_Num == '0) begin
              state <= FLUSH;
              Done  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // Lets a stale M_Ready from the previous row settle.
          if (gap_cnt == 2'd2) begin
            gap_cnt <= '0;
            state   <= WAIT;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        WAIT: begin
          if (M_Ready) begin
            state <= READ;
          end
        end
        READ: begin
          if (rd_en && last_word) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && count == 2'd0) begin
            issued <= '0;
            if (row_cnt == rn_q - R_ONE) begin
              state    <= FLUSH;
              Next_Reg <= 1'b1;
              Done     <= 1'b1;
            end else begin
              row_cnt <= row_cnt + R_ONE;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_conv11_reader.sv
// Directed bench for feature_conv11_reader.
// FIFO model feeds indexed words; a monitor scores order, last flags and stalls.
module tb_feature_conv11_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [10:0]  Row_Words;
  logic [11:0]  Row_Num;
  logic         M_Ready;
  logic [10:0]  M_count;
  logic         rd_en;
  logic [255:0] fifo_dout;
  logic         Next_Reg;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         Done;
  logic         Busy;

  feature_conv11_reader dut (
    .clk(clk), .rst(rst), .Start(Start),
    .Row_Words(Row_Words), .Row_Num(Row_Num),
    .M_Ready(M_Ready), .M_count(M_count),
    .rd_en(rd_en), .fifo_dout(fifo_dout),
    .Next_Reg(Next_Reg), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .Done(Done), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_idx = 0;
  int cur_rw = 1;
  int n_rd = 0, n_acc = 0, n_last = 0;
  int n_next = 0, n_done = 0, n_stall = 0;
  int rd_cycs[$];
  int acc_cycs[$];

  function automatic logic [255:0] word_val(input int i);
    return {8{32'hC0DE0000 ^ 32'(i)}};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      fifo_dout <= word_val(rd_idx);
      rd_idx    <= rd_idx + 1;
    end
  end

  int mocc, minf, nxt, exp_idx, wir;
  logic stall;
  logic [255:0] held;
  logic pop;

  always @(negedge clk) begin
    if (rst) begin
      mocc = 0; minf = 0; wir = 0;
      stall = 1'b0;
      exp_idx = rd_idx;
    end else begin
      if (stall) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout, held);
      end
      chk("valid_vs_occ", dout_valid, mocc != 0);
      pop = dout_valid && dout_ready;
      if (rd_en) begin
        n_rd++;
        rd_cycs.push_back(cyc);
      end
      if (pop) begin
        chk("word", dout, word_val(exp_idx));
        chk("last", dout_last, wir == cur_rw - 1);
        exp_idx++;
        n_acc++;
        acc_cycs.push_back(cyc);
        if (dout_last) n_last++;
        wir = (wir == cur_rw - 1) ? 0 : wir + 1;
      end
      stall = dout_valid && !dout_ready;
      if (stall) n_stall++;
      held = dout;
      nxt = mocc - (pop ? 1 : 0) + minf;
      if (rd_en) chk("credit", (nxt + 1) <= 2, 1);
      mocc = nxt;
      minf = rd_en ? 1 : 0;
      if (Next_Reg) n_next++;
      if (Done) n_done++;
    end
  end

  int s_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int rw, input int rn);
    Row_Words = 11'(rw);
    Row_Num   = 12'(rn);
    Start     = 1'b1;
    s_cyc     = cyc;
    tick();
    Start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (Done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (Done !== 1'b1) chk("done_timeout", Done, 1);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int k = 0;
    while (n_rd < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_rd < target) chk("rd_timeout", n_rd, target);
  endtask

  int b_rd, b_acc, b_last, b_next, b_done, b_stall;

  task automatic mark();
    b_rd = n_rd; b_acc = n_acc; b_last = n_last;
    b_next = n_next; b_done = n_done; b_stall = n_stall;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Row_Words = '0; Row_Num = '0;
    M_Ready = 1'b0; dout_ready = 1'b0; fifo_dout = '0;
    tick(); tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_mcount", M_count, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    tick();

    // single row of 4
    M_Ready = 1'b1; dout_ready = 1'b1; cur_rw = 4;
    mark();
    start(4, 1);
    chk("t1_mcount", M_count, 4);
    chk("t1_busy", Busy, 1);
    wait_done(40);
    chk("t1_done_cyc", cyc, s_cyc + 12);
    chk("t1_next_with_done", Next_Reg, 1);
    @(negedge clk);
    chk("t1_busy_fall", Busy, 0);
    chk("t1_done_pulse", Done, 0);
    chk("t1_rd_cnt", n_rd - b_rd, 4);
    chk("t1_first_rd", rd_cycs[b_rd], s_cyc + 5);
    chk("t1_rd_burst", rd_cycs[b_rd + 3] - rd_cycs[b_rd], 3);
    chk("t1_first_acc", acc_cycs[b_acc], s_cyc + 7);
    chk("t1_acc_cnt", n_acc - b_acc, 4);
    chk("t1_last_cnt", n_last - b_last, 1);
    chk("t1_next_cnt", n_next - b_next, 1);
    tick();

    // 2x2 with M_Ready high: row-to-row read spacing
    cur_rw = 2;
    mark();
    start(2, 2);
    wait_done(60);
    tick();
    chk("t2b_rd_cnt", n_rd - b_rd, 4);
    chk("t2b_row_gap", rd_cycs[b_rd + 2] - rd_cycs[b_rd + 1], 8);

    // 3 rows of 8, M_Ready raised late per row
    M_Ready = 1'b0; cur_rw = 8;
    mark();
    start(8, 3);
    for (int r = 0; r < 3; r++) begin
      repeat (10) tick();
      chk("t2_no_rd_wait", n_rd - b_rd, 8 * r);
      M_Ready = 1'b1;
      wait_rd(b_rd + 8 * (r + 1), 40);
      M_Ready = 1'b0;
    end
    wait_done(40);
    tick();
    chk("t2_acc_cnt", n_acc - b_acc, 24);
    chk("t2_last_cnt", n_last - b_last, 3);
    chk("t2_next_cnt", n_next - b_next, 1);
    chk("t2_done_cnt", n_done - b_done, 1);

    // stalling consumer
    M_Ready = 1'b1; cur_rw = 6;
    mark();
    start(6, 1);
    for (int k = 0; k < 80 && Done !== 1'b1; k++) begin
      dout_ready = ~dout_ready;
      tick();
    end
    dout_ready = 1'b1;
    wait_done(20);
    tick();
    chk("t3_acc_cnt", n_acc - b_acc, 6);
    chk("t3_last_cnt", n_last - b_last, 1);
    chk("t3_stalled", (n_stall - b_stall) > 0, 1);

    // empty layers
    mark();
    start(0, 5);
    chk("t4a_done", Done, 1);
    chk("t4a_next", Next_Reg, 0);
    chk("t4a_mcount", M_count, 0);
    tick();
    chk("t4a_done_pulse", Done, 0);
    chk("t4a_idle", Busy, 0);
    start(3, 0);
    chk("t4b_done", Done, 1);
    chk("t4b_next", Next_Reg, 0);
    chk("t4b_mcount", M_count, 3);
    tick(); tick();
    chk("t4_rd_cnt", n_rd - b_rd, 0);
    chk("t4_next_cnt", n_next - b_next, 0);
    chk("t4_done_cnt", n_done - b_done, 2);

    // async reset mid-burst
    cur_rw = 8;
    mark();
    start(8, 1);
    wait_rd(b_rd + 3, 40);
    #1 rst = 1'b1;
    #1;
    chk("t5_rd_en", rd_en, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_dout", dout, 0);
    chk("t5_busy", Busy, 0);
    chk("t5_mcount", M_count, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    cur_rw = 2;
    mark();
    start(2, 1);
    wait_done(40);
    tick();
    chk("t5_rd_cnt", n_rd - b_rd, 2);
    chk("t5_acc_cnt", n_acc - b_acc, 2);
    chk("t5_no_next_on_rst", n_next - b_next, 1);

    // Start during READ is ignored
    cur_rw = 5;
    mark();
    start(5, 2);
    wait_rd(b_rd + 2, 40);
    Row_Words = 11'd1; Row_Num = 12'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(80);
    tick();
    chk("t6_rd_cnt", n_rd - b_rd, 10);
    chk("t6_acc_cnt", n_acc - b_acc, 10);
    chk("t6_last_cnt", n_last - b_last, 2);
    chk("t6_done_cnt", n_done - b_done, 1);
    chk("t6_mcount", M_count, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
